// File: rtl/mchan_arb_pkg.sv
// Shared types and index helpers for the mchan weighted round-robin arbiter.
// Helpers work on a fixed-width mask; callers zero-extend so unused lanes never win.
package mchan_arb_pkg;

    localparam int MAX_MASTER = 32;

    typedef enum logic {
        ARB,
        LOCKED
    } arb_state_e;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } pick_t;

    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

    // Lanes at or above the real master count are always zero in the mask, so
    // wrapping at MAX_MASTER picks the same winner as wrapping at N_MASTER.
    function automatic pick_t rr_pick(input logic [MAX_MASTER-1:0] mask, input int ptr);
        pick_t res;
        int    j;
        res.found = 1'b0;
        res.idx   = '0;
        for (int i = 0; i < MAX_MASTER; i++) begin
            j = (ptr + i) % MAX_MASTER;
            if (!res.found && mask[j]) begin
                res.found = 1'b1;
                res.idx   = j;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mchan_arb_out_reg.sv
// One-entry valid/ready register carrying the arbitration winner's {data, id, last}.
module mchan_arb_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    input  logic                  last_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [ID_WIDTH-1:0]   id_o,
    output logic                  last_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  last_q;

    // Accept a new beat whenever the slot is empty or is draining this cycle.
    assign ready_o = !valid_q || ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            last_q  <= 1'b0;
        end else if (valid_i && ready_o) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            id_q    <= id_i;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign id_o    = id_q;
    assign last_o  = last_q;

endmodule

// File: rtl/mchan_wrr_arbiter.sv
// Weighted round-robin N-to-1 arbiter with burst locking and optional output register.
// Supports 1 to 32 masters; credits refill in the same cycle they run dry.
module mchan_wrr_arbiter
    import mchan_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int N_MASTER     = 4,
    parameter int LOG_MASTER   = (N_MASTER == 1) ? 1 : $clog2(N_MASTER),
    parameter int WEIGHT_WIDTH = 4,
    parameter int OUT_REG      = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_MASTER-1:0]              req_i,
    output logic [N_MASTER-1:0]              gnt_o,
    input  logic [N_MASTER*DATA_WIDTH-1:0]   data_i,
    input  logic [N_MASTER-1:0]              last_i,
    input  logic [N_MASTER*WEIGHT_WIDTH-1:0] weight_i,
    output logic                             req_o,
    input  logic                             gnt_i,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic [LOG_MASTER-1:0]            id_o,
    output logic                             last_o
);

    arb_state_e              state_q, state_d;
    logic [LOG_MASTER-1:0]   owner_q, owner_d;
    logic [LOG_MASTER-1:0]   ptr_q, ptr_d;
    logic [WEIGHT_WIDTH-1:0] credit_q [N_MASTER];
    logic [WEIGHT_WIDTH-1:0] credit_d [N_MASTER];

    logic [N_MASTER-1:0]     credited;
    logic [N_MASTER-1:0]     eligible;
    logic                    refill;
    pick_t                   pick;
    logic                    found;
    logic [LOG_MASTER-1:0]   win;
    logic [DATA_WIDTH-1:0]   selData;
    logic                    selLast;
    logic                    upReady;
    logic                    accept;

    // When nobody holding credit is requesting, every requester competes and the
    // credits are refilled at the same edge, so a refill never costs a cycle.
    always_comb begin
        credited = '0;
        eligible = '0;
        refill   = 1'b0;
        for (int k = 0; k < N_MASTER; k++) begin
            credited[k] = req_i[k] && (credit_q[k] != '0);
        end
        if (state_q == LOCKED) begin
            for (int k = 0; k < N_MASTER; k++) begin
                eligible[k] = req_i[k] && (owner_q == LOG_MASTER'(k));
            end
        end else if (N_MASTER == 1) begin
            eligible = req_i;
        end else if (credited != '0) begin
            eligible = credited;
        end else begin
            eligible = req_i;
            refill   = |req_i;
        end
        pick  = rr_pick(MAX_MASTER'(eligible), int'(ptr_q));
        found = pick.found;
        win   = '0;
        for (int k = 0; k < N_MASTER; k++) begin
            if (pick.idx == 32'(k)) begin
                win = LOG_MASTER'(k);
            end
        end
    end

    always_comb begin
        selData = '0;
        selLast = 1'b0;
        gnt_o   = '0;
        for (int k = 0; k < N_MASTER; k++) begin
            if (win == LOG_MASTER'(k)) begin
                selData  = data_i[k*DATA_WIDTH +: DATA_WIDTH];
                selLast  = last_i[k];
                gnt_o[k] = accept;
            end
        end
    end

    assign accept = found && upReady;

    always_comb begin : next_state
        logic [WEIGHT_WIDTH-1:0] wEff;
        logic                    dec;
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (accept) begin
            if (selLast) begin
                state_d = ARB;
                ptr_d   = LOG_MASTER'(next_idx(int'(win), N_MASTER));
            end else begin
                state_d = LOCKED;
                owner_d = win;
            end
        end
        for (int k = 0; k < N_MASTER; k++) begin
            wEff        = weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            wEff        = (wEff == '0) ? WEIGHT_WIDTH'(1) : wEff;
            dec         = accept && selLast && (win == LOG_MASTER'(k));
            credit_d[k] = credit_q[k];
            if (refill) begin
                credit_d[k] = dec ? (wEff - WEIGHT_WIDTH'(1)) : wEff;
            end else if (dec && (credit_q[k] != '0)) begin
                credit_d[k] = credit_q[k] - WEIGHT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            owner_q <= '0;
            ptr_q   <= '0;
            for (int k = 0; k < N_MASTER; k++) begin
                credit_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            for (int k = 0; k < N_MASTER; k++) begin
                credit_q[k] <= credit_d[k];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        mchan_arb_out_reg #(
            .DATA_WIDTH(DATA_WIDTH),
            .ID_WIDTH  (LOG_MASTER)
        ) u_out_reg (
            .clk    (clk),
            .rst_n  (rst_n),
            .valid_i(found),
            .ready_o(upReady),
            .data_i (selData),
            .id_i   (win),
            .last_i (selLast),
            .valid_o(req_o),
            .ready_i(gnt_i),
            .data_o (data_o),
            .id_o   (id_o),
            .last_o (last_o)
        );
    end else begin : g_out_comb
        assign upReady = gnt_i;
        assign req_o   = found;
        assign data_o  = selData;
        assign id_o    = win;
        assign last_o  = selLast;
    end

endmodule

// File: tb/tb_mchan_wrr_arbiter.sv
// Bench for mchan_wrr_arbiter: directed scenarios plus randomized traffic against a
// credit/pointer/lock model kept as plain integers.
module tb_mchan_wrr_arbiter;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      req = '0;
    logic [3:0]      last = '0;
    logic [4*DW-1:0] data = '0;
    logic [15:0]     wts = '0;
    logic            gnt = 1'b0;

    logic [3:0]    gnt4, gntR;
    logic [2:0]    gnt3;
    logic          reqO4, reqOR, reqO3;
    logic [DW-1:0] dataO4, dataOR, dataO3;
    logic [1:0]    idO4, idOR, idO3;
    logic          lastO4, lastOR, lastO3;

    always #5 clk = ~clk;

    mchan_wrr_arbiter #(.DATA_WIDTH(DW), .N_MASTER(4), .WEIGHT_WIDTH(4), .OUT_REG(0)) u4 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt4), .data_i(data), .last_i(last),
        .weight_i(wts), .req_o(reqO4), .gnt_i(gnt), .data_o(dataO4), .id_o(idO4), .last_o(lastO4)
    );

    mchan_wrr_arbiter #(.DATA_WIDTH(DW), .N_MASTER(4), .WEIGHT_WIDTH(4), .OUT_REG(1)) u4r (
        .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gntR), .data_i(data), .last_i(last),
        .weight_i(wts), .req_o(reqOR), .gnt_i(gnt), .data_o(dataOR), .id_o(idOR), .last_o(lastOR)
    );

    mchan_wrr_arbiter #(.DATA_WIDTH(DW), .N_MASTER(3), .WEIGHT_WIDTH(4), .OUT_REG(1)) u3 (
        .clk(clk), .rst_n(rst_n), .req_i(req[2:0]), .gnt_o(gnt3), .data_i(data[3*DW-1:0]),
        .last_i(last[2:0]), .weight_i(wts[11:0]), .req_o(reqO3), .gnt_i(gnt), .data_o(dataO3),
        .id_o(idO3), .last_o(lastO3)
    );

    int checks = 0;
    int errors = 0;

    int inst;
    int nM;
    bit outReg;
    logic [3:0]    oGnt;
    logic          oReq;
    logic [DW-1:0] oData;
    logic [1:0]    oId;
    logic          oLast;

    int            mCredit [4];
    int            mPtr;
    int            mOwner;
    bit            mValid;
    logic [DW-1:0] mData;
    int            mId;
    bit            mLast;

    task automatic applyReset();
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        gnt   = 1'b0;
        data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic modelReset();
        for (int k = 0; k < 4; k++) mCredit[k] = 0;
        mPtr   = 0;
        mOwner = -1;
        mValid = 1'b0;
        mData  = '0;
        mId    = 0;
        mLast  = 1'b0;
    endtask

    task automatic sampleOutputs();
        case (inst)
            0: begin oGnt = gnt4; oReq = reqO4; oData = dataO4; oId = idO4; oLast = lastO4; end
            1: begin oGnt = gntR; oReq = reqOR; oData = dataOR; oId = idOR; oLast = lastOR; end
            default: begin oGnt = {1'b0, gnt3}; oReq = reqO3; oData = dataO3; oId = idO3; oLast = lastO3; end
        endcase
    endtask

    // Winner: the lock owner if locked; else the first credited requester from the
    // pointer; else any requester, with a refill of all credits.
    task automatic modelPick(input logic [3:0] r, output int win, output bit refill);
        int k;
        win    = -1;
        refill = 1'b0;
        if (mOwner >= 0) begin
            if (r[mOwner]) win = mOwner;
        end else begin
            for (int i = 0; i < nM; i++) begin
                k = (mPtr + i) % nM;
                if (win < 0 && r[k] && mCredit[k] > 0) win = k;
            end
            if (win < 0) begin
                for (int i = 0; i < nM; i++) begin
                    k = (mPtr + i) % nM;
                    if (win < 0 && r[k]) begin
                        win    = k;
                        refill = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic modelStep(input int win, input bit refill, input bit acc);
        int w;
        if (refill) begin
            for (int k = 0; k < nM; k++) begin
                w = int'(wts[k*4 +: 4]);
                mCredit[k] = (w == 0) ? 1 : w;
            end
        end
        if (acc) begin
            if (last[win]) begin
                mOwner = -1;
                mPtr   = (win + 1) % nM;
                if (mCredit[win] > 0) mCredit[win] = mCredit[win] - 1;
            end else begin
                mOwner = win;
            end
            if (outReg) begin
                mValid = 1'b1;
                mData  = data[win*DW +: DW];
                mId    = win;
                mLast  = last[win];
            end
        end else if (outReg && gnt) begin
            mValid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        gnt   = 1'b0;
        #1;
        checks++; if (reqOR !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_o got %b exp 0", reqOR); end
        checks++; if (idOR !== 2'd0) begin errors++; $display("[TB] FAIL reset_id_o got %0d exp 0", idOR); end
        checks++; if (dataOR !== '0) begin errors++; $display("[TB] FAIL reset_data_o got %h exp 0", dataOR); end
        checks++; if (lastOR !== 1'b0) begin errors++; $display("[TB] FAIL reset_last_o got %b exp 0", lastOR); end
        checks++; if (reqO3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_o_n3 got %b exp 0", reqO3); end
        checks++; if (gnt4 !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt_o got %b exp 0000", gnt4); end
        applyReset();
    endtask

    task automatic test_weighting();
        int expW [18] = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0, 0, 1, 2, 3, 0, 0, 0};
        logic [3:0] e;
        applyReset();
        wts  = 16'h1113;
        req  = 4'hF;
        last = 4'hF;
        gnt  = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            e = 4'(1 << expW[i]);
            checks++; if (gnt4 !== e) begin errors++; $display("[TB] FAIL weighting[%0d] gnt_o got %b exp %b", i, gnt4, e); end
            checks++; if (idO4 !== 2'(expW[i])) begin errors++; $display("[TB] FAIL weighting[%0d] id_o got %0d exp %0d", i, idO4, expW[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_burst_lock();
        applyReset();
        wts  = 16'h1111;
        gnt  = 1'b1;
        req  = 4'b0001;
        last = 4'b1111;
        #1;
        checks++; if (gnt4 !== 4'b0001) begin errors++; $display("[TB] FAIL burst_setup gnt_o got %b exp 0001", gnt4); end
        @(negedge clk);
        req = 4'b0111;
        for (int b = 0; b < 4; b++) begin
            last = (b == 3) ? 4'b1111 : 4'b1101;
            #1;
            checks++; if (gnt4 !== 4'b0010) begin errors++; $display("[TB] FAIL burst_beat%0d gnt_o got %b exp 0010", b, gnt4); end
            @(negedge clk);
        end
        req  = 4'b0101;
        last = 4'b1111;
        #1;
        checks++; if (gnt4 !== 4'b0100) begin errors++; $display("[TB] FAIL burst_after1 gnt_o got %b exp 0100", gnt4); end
        @(negedge clk);
        #1;
        checks++; if (gnt4 !== 4'b0001) begin errors++; $display("[TB] FAIL burst_after2 gnt_o got %b exp 0001", gnt4); end
        @(negedge clk);
    endtask

    task automatic test_weight_zero();
        int expZ [9] = '{0, 1, 1, 0, 1, 1, 0, 1, 1};
        logic [3:0] e;
        applyReset();
        wts  = 16'h0020;
        req  = 4'b0011;
        last = 4'hF;
        gnt  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            e = 4'(1 << expZ[i]);
            checks++; if (gnt4 !== e) begin errors++; $display("[TB] FAIL weight_zero[%0d] gnt_o got %b exp %b", i, gnt4, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] data0, data1;
        applyReset();
        wts  = 16'h1111;
        req  = 4'hF;
        last = 4'hF;
        gnt  = 1'b0;
        data = {$urandom, $urandom};
        #1;
        checks++; if (gntR !== 4'b0001) begin errors++; $display("[TB] FAIL bp_fill gnt_o got %b exp 0001", gntR); end
        data0 = data[DW-1:0];
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            data = {$urandom, $urandom};
            #1;
            checks++; if (reqOR !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold[%0d] req_o got %b exp 1", i, reqOR); end
            checks++; if (idOR !== 2'd0) begin errors++; $display("[TB] FAIL bp_hold[%0d] id_o got %0d exp 0", i, idOR); end
            checks++; if (dataOR !== data0) begin errors++; $display("[TB] FAIL bp_hold[%0d] data_o got %h exp %h", i, dataOR, data0); end
            checks++; if (gntR !== 4'b0000) begin errors++; $display("[TB] FAIL bp_hold[%0d] gnt_o got %b exp 0000", i, gntR); end
            @(negedge clk);
        end
        gnt  = 1'b1;
        data = {$urandom, $urandom};
        #1;
        checks++; if (gntR !== 4'b0010) begin errors++; $display("[TB] FAIL bp_release gnt_o got %b exp 0010", gntR); end
        data1 = data[2*DW-1:DW];
        @(negedge clk);
        #1;
        checks++; if (idOR !== 2'd1) begin errors++; $display("[TB] FAIL bp_next id_o got %0d exp 1", idOR); end
        checks++; if (dataOR !== data1) begin errors++; $display("[TB] FAIL bp_next data_o got %h exp %h", dataOR, data1); end
        gnt = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        applyReset();
        wts  = 16'h1111;
        gnt  = 1'b1;
        req  = 4'b1000;
        last = 4'b0000;
        @(negedge clk);
        #1;
        checks++; if (gntR !== 4'b1000) begin errors++; $display("[TB] FAIL midrst_locked gnt_o got %b exp 1000", gntR); end
        checks++; if (idOR !== 2'd3) begin errors++; $display("[TB] FAIL midrst_beat1 id_o got %0d exp 3", idOR); end
        rst_n = 1'b0;
        #1;
        checks++; if (reqOR !== 1'b0) begin errors++; $display("[TB] FAIL midrst_req_o got %b exp 0", reqOR); end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1001;
        last  = 4'b1111;
        #1;
        checks++; if (gntR !== 4'b0001) begin errors++; $display("[TB] FAIL midrst_after gnt_o got %b exp 0001", gntR); end
        @(negedge clk);
        #1;
        checks++; if (idOR !== 2'd0 || reqOR !== 1'b1) begin errors++; $display("[TB] FAIL midrst_after id_o got %0d req_o %b exp 0/1", idOR, reqOR); end
        @(negedge clk);
    endtask

    task automatic test_non_pow2();
        applyReset();
        wts  = 16'h0111;
        req  = 4'hF;
        last = 4'hF;
        gnt  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++; if (reqO3 !== 1'b1) begin errors++; $display("[TB] FAIL n3[%0d] req_o got %b exp 1", i, reqO3); end
            checks++; if (idO3 !== 2'(i % 3)) begin errors++; $display("[TB] FAIL n3[%0d] id_o got %0d exp %0d", i, idO3, i % 3); end
        end
        @(negedge clk);
    endtask

    task automatic test_random(input int which, input int n, input bit withReg, input int cycles);
        int win;
        bit refill;
        bit acc;
        logic [3:0] expGnt;
        inst   = which;
        nM     = n;
        outReg = withReg;
        applyReset();
        modelReset();
        for (int k = 0; k < 4; k++) wts[k*4 +: 4] = 4'($urandom_range(0, 3));
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < 4; k++) begin
                req[k]  = ($urandom_range(0, 9) < 7);
                last[k] = 1'($urandom_range(0, 1));
            end
            gnt  = ($urandom_range(0, 3) != 0);
            data = {$urandom, $urandom};
            #1;
            sampleOutputs();
            modelPick(req, win, refill);
            acc    = (win >= 0) && (outReg ? (!mValid || gnt) : gnt);
            expGnt = acc ? 4'(1 << win) : 4'b0000;
            checks++; if (oGnt !== expGnt) begin errors++; $display("[TB] FAIL rand%0d[%0d] gnt_o got %b exp %b", which, c, oGnt, expGnt); end
            if (outReg) begin
                checks++; if (oReq !== mValid) begin errors++; $display("[TB] FAIL rand%0d[%0d] req_o got %b exp %b", which, c, oReq, mValid); end
                checks++; if (oId !== 2'(mId) || oData !== mData || oLast !== mLast) begin
                    errors++;
                    $display("[TB] FAIL rand%0d[%0d] out got id %0d data %h last %b exp %0d %h %b", which, c, oId, oData, oLast, mId, mData, mLast);
                end
            end else begin
                checks++; if (oReq !== (win >= 0)) begin errors++; $display("[TB] FAIL rand%0d[%0d] req_o got %b exp %b", which, c, oReq, win >= 0); end
                if (win >= 0) begin
                    checks++; if (oId !== 2'(win) || oData !== data[win*DW +: DW] || oLast !== last[win]) begin
                        errors++;
                        $display("[TB] FAIL rand%0d[%0d] out got id %0d data %h last %b exp %0d %h %b", which, c, oId, oData, oLast, win, data[win*DW +: DW], last[win]);
                    end
                end
            end
            modelStep(win, refill, acc);
            @(negedge clk);
        end
    endtask

    initial begin
        inst   = 0;
        nM     = 4;
        outReg = 1'b0;
        modelReset();
        test_reset();
        test_weighting();
        test_burst_lock();
        test_weight_zero();
        test_backpressure();
        test_reset_mid_burst();
        test_non_pow2();
        test_random(0, 4, 1'b0, 300);
        test_random(1, 4, 1'b1, 300);
        test_random(2, 3, 1'b1, 300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
